// File: rtl/filter_ctrl_multi.sv
// Multi-channel filter controller: one Pico 4-phase req/ack link feeding
// N_CH independent fill/circulate/drain channel FSMs with shared pump PWM.
module filter_ctrl_multi #(
  parameter int N_CH          = 2,
  parameter int CH_W          = 1,
  parameter int SENS_W        = 4,
  parameter int PWM_W         = 8,
  parameter int DUTY_A        = 192,
  parameter int DUTY_B        = 128,
  parameter int FILL_TIMEOUT  = 100000,
  parameter int DRAIN_TIMEOUT = 100000,
  parameter int ACK_TIMEOUT   = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_W+SENS_W-1:0] pico_data_in,
  input  logic                   pico_req_in,
  output logic                   pico_ack_out,
  input  logic [N_CH-1:0]        float_full_in,
  input  logic [N_CH-1:0]        float_empty_in,
  output logic [N_CH-1:0]        pump_a_pwm_out,
  output logic [N_CH-1:0]        pump_b_pwm_out,
  output logic                   comm_error_led_out,
  output logic [N_CH-1:0]        fault_out
);

  localparam int W     = CH_W + SENS_W;
  localparam int T_MAX = (FILL_TIMEOUT > DRAIN_TIMEOUT) ? FILL_TIMEOUT : DRAIN_TIMEOUT;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int PW1   = PWM_W + 1;
  localparam int CW1   = CH_W + 1;
  localparam logic [TMR_W-1:0] FILL_LAST  = TMR_W'(FILL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_SAT    = TMR_W'(T_MAX);
  localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [PW1-1:0]   DUTY_A_W   = PW1'(DUTY_A);
  localparam logic [PW1-1:0]   DUTY_B_W   = PW1'(DUTY_B);
  localparam logic [CW1-1:0]   N_CH_W     = CW1'(N_CH);

  typedef enum logic [1:0] {L_IDLE = 2'd0, L_ACK = 2'd1, L_WAIT_LOW = 2'd2} link_state_e;
  typedef enum logic [2:0] {
    IDLE = 3'd0, FILLING = 3'd1, CIRCULATING = 3'd2, DRAINING = 3'd3, FAULT = 3'd4
  } ch_state_e;

  logic              req_meta_r, req_sync_r;
  logic [N_CH-1:0]   full_meta_r, full_sync_r, empty_meta_r, empty_sync_r;
  link_state_e       link_state_r, link_next_s;
  logic [W-1:0]      data_r, data_next_s;
  logic              ack_r, ack_next_s;
  logic [ACK_W-1:0]  ack_cnt_r, ack_cnt_next_s;
  logic              comm_err_r, comm_err_next_s;
  logic [CH_W-1:0]   ch_idx_s;
  logic [SENS_W-1:0] anom_s;
  logic              word_valid_s, apply_s, word_anom_s;
  ch_state_e         ch_state_r [N_CH];
  ch_state_e         ch_next_s [N_CH];
  logic [TMR_W-1:0]  timer_r [N_CH];
  logic [TMR_W-1:0]  timer_next_s [N_CH];
  logic [N_CH-1:0]   hit_s, both_s, en_a_s, en_b_s;
  logic [PWM_W-1:0]  pwm_cnt_r;
  logic              duty_a_on_s, duty_b_on_s;
  logic [N_CH-1:0]   pump_a_r, pump_b_r, fault_r;

  // Two-flop synchronisers for the asynchronous request and float switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_r   <= 1'b0;
      req_sync_r   <= 1'b0;
      full_meta_r  <= {N_CH{1'b0}};
      full_sync_r  <= {N_CH{1'b0}};
      empty_meta_r <= {N_CH{1'b0}};
      empty_sync_r <= {N_CH{1'b0}};
    end else begin
      req_meta_r   <= pico_req_in;
      req_sync_r   <= req_meta_r;
      full_meta_r  <= float_full_in;
      full_sync_r  <= full_meta_r;
      empty_meta_r <= float_empty_in;
      empty_sync_r <= empty_meta_r;
    end
  end

  // Decode of the captured status word; it only acts on a channel during L_ACK
  always_comb begin
    ch_idx_s     = data_r[W-1:SENS_W];
    anom_s       = data_r[SENS_W-1:0];
    word_valid_s = !(&anom_s) && ({1'b0, ch_idx_s} < N_CH_W);
    word_anom_s  = |anom_s;
    apply_s      = (link_state_r == L_ACK) && word_valid_s;
  end

  // Link FSM next state: capture, one-cycle apply, wait for req low, ack timeout
  always_comb begin
    link_next_s     = link_state_r;
    data_next_s     = data_r;
    ack_next_s      = ack_r;
    ack_cnt_next_s  = ack_cnt_r;
    comm_err_next_s = comm_err_r;
    case (link_state_r)
      L_IDLE: begin
        if (req_sync_r) begin
          data_next_s    = pico_data_in;
          ack_next_s     = 1'b1;
          ack_cnt_next_s = {ACK_W{1'b0}};
          link_next_s    = L_ACK;
        end else begin
          link_next_s = L_IDLE;
        end
      end
      L_ACK: begin
        comm_err_next_s = !word_valid_s;
        ack_cnt_next_s  = ack_cnt_r + 1'b1;
        link_next_s     = L_WAIT_LOW;
      end
      L_WAIT_LOW: begin
        if (!req_sync_r) begin
          ack_next_s  = 1'b0;
          link_next_s = L_IDLE;
        end else if (ack_r && (ack_cnt_r >= ACK_LAST)) begin
          // Pico never released req: flag it, drop ack, keep waiting for req low
          ack_next_s      = 1'b0;
          comm_err_next_s = 1'b1;
        end else if (ack_r) begin
          ack_cnt_next_s = ack_cnt_r + 1'b1;
        end else begin
          ack_cnt_next_s = ack_cnt_r;
        end
      end
      default: begin
        ack_next_s  = 1'b0;
        link_next_s = L_IDLE;
      end
    endcase
  end

  // Link FSM state and registered link outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_state_r <= L_IDLE;
      data_r       <= {W{1'b0}};
      ack_r        <= 1'b0;
      ack_cnt_r    <= {ACK_W{1'b0}};
      comm_err_r   <= 1'b0;
    end else begin
      link_state_r <= link_next_s;
      data_r       <= data_next_s;
      ack_r        <= ack_next_s;
      ack_cnt_r    <= ack_cnt_next_s;
      comm_err_r   <= comm_err_next_s;
    end
  end

  // Per-channel word hit and contradictory-sensor detection
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hit_s[i]  = apply_s && (ch_idx_s == CH_W'(i));
      both_s[i] = full_sync_r[i] && empty_sync_r[i];
    end
  end

  // Channel FSM next state and timers; a word on the same cycle beats sensors
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_next_s[i] = ch_state_r[i];
      case (ch_state_r[i])
        IDLE: begin
          if (hit_s[i])       ch_next_s[i] = word_anom_s ? FILLING : IDLE;
          else if (both_s[i]) ch_next_s[i] = FAULT;
          else                ch_next_s[i] = IDLE;
        end
        FILLING: begin
          if (hit_s[i])                      ch_next_s[i] = word_anom_s ? FILLING : DRAINING;
          else if (both_s[i])                ch_next_s[i] = FAULT;
          else if (full_sync_r[i])           ch_next_s[i] = CIRCULATING;
          else if (timer_r[i] >= FILL_LAST)  ch_next_s[i] = FAULT;
          else                               ch_next_s[i] = FILLING;
        end
        CIRCULATING: begin
          if (hit_s[i])       ch_next_s[i] = word_anom_s ? CIRCULATING : DRAINING;
          else if (both_s[i]) ch_next_s[i] = FAULT;
          else                ch_next_s[i] = CIRCULATING;
        end
        DRAINING: begin
          if (hit_s[i])                      ch_next_s[i] = word_anom_s ? FILLING : DRAINING;
          else if (both_s[i])                ch_next_s[i] = FAULT;
          else if (empty_sync_r[i])          ch_next_s[i] = IDLE;
          else if (timer_r[i] >= DRAIN_LAST) ch_next_s[i] = FAULT;
          else                               ch_next_s[i] = DRAINING;
        end
        FAULT: begin
          // Recovery needs an OK word while the tank reads plainly empty
          if (hit_s[i] && !word_anom_s && empty_sync_r[i] && !full_sync_r[i])
            ch_next_s[i] = IDLE;
          else
            ch_next_s[i] = FAULT;
        end
        default: ch_next_s[i] = FAULT;
      endcase
      if (ch_next_s[i] != ch_state_r[i])  timer_next_s[i] = {TMR_W{1'b0}};
      else if (timer_r[i] != TMR_SAT)     timer_next_s[i] = timer_r[i] + 1'b1;
      else                                timer_next_s[i] = timer_r[i];
    end
  end

  // Pump enables from the current channel state
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      en_a_s[i] = (ch_state_r[i] == FILLING) || (ch_state_r[i] == CIRCULATING);
      en_b_s[i] = (ch_state_r[i] == CIRCULATING) || (ch_state_r[i] == DRAINING);
    end
    duty_a_on_s = ({1'b0, pwm_cnt_r} < DUTY_A_W);
    duty_b_on_s = ({1'b0, pwm_cnt_r} < DUTY_B_W);
  end

  // Channel state, timers, shared PWM counter and registered pump/fault outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_state_r[i] <= IDLE;
        timer_r[i]    <= {TMR_W{1'b0}};
      end
      pwm_cnt_r <= {PWM_W{1'b0}};
      pump_a_r  <= {N_CH{1'b0}};
      pump_b_r  <= {N_CH{1'b0}};
      fault_r   <= {N_CH{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        ch_state_r[i] <= ch_next_s[i];
        timer_r[i]    <= timer_next_s[i];
        pump_a_r[i]   <= en_a_s[i] && duty_a_on_s;
        pump_b_r[i]   <= en_b_s[i] && duty_b_on_s;
        fault_r[i]    <= (ch_next_s[i] == FAULT);
      end
      pwm_cnt_r <= pwm_cnt_r + 1'b1;
    end
  end

  assign pico_ack_out       = ack_r;
  assign comm_error_led_out = comm_err_r;
  assign pump_a_pwm_out     = pump_a_r;
  assign pump_b_pwm_out     = pump_b_r;
  assign fault_out          = fault_r;

endmodule

// File: tb/tb_filter_ctrl_multi.sv
// Self-checking bench for filter_ctrl_multi: vector table, directed corner
// sequences and a randomized phase against a settled-state reference model.
module tb_filter_ctrl_multi;

  localparam int NC = 3;
  localparam int DA = 192;
  localparam int DB = 128;
  localparam int M_IDLE = 0, M_FILL = 1, M_CIRC = 2, M_DRAIN = 3, M_FAULT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    pico_data_in;
  logic          pico_req_in;
  logic          pico_ack_out;
  logic [NC-1:0] float_full_in, float_empty_in;
  logic [NC-1:0] pump_a_pwm_out, pump_b_pwm_out, fault_out;
  logic          comm_error_led_out;

  int checks = 0;
  int errors = 0;
  int a_cnt [NC];
  int b_cnt [NC];
  int m_state [NC];

  typedef struct {
    logic [5:0] word;
    bit         exp_err;
  } vec_t;
  vec_t vecs [6];

  filter_ctrl_multi #(
    .N_CH(NC), .CH_W(2), .SENS_W(4), .PWM_W(8), .DUTY_A(DA), .DUTY_B(DB),
    .FILL_TIMEOUT(50), .DRAIN_TIMEOUT(400), .ACK_TIMEOUT(60)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pico_data_in(pico_data_in), .pico_req_in(pico_req_in),
    .pico_ack_out(pico_ack_out), .float_full_in(float_full_in), .float_empty_in(float_empty_in),
    .pump_a_pwm_out(pump_a_pwm_out), .pump_b_pwm_out(pump_b_pwm_out),
    .comm_error_led_out(comm_error_led_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Full 4-phase handshake with bounded waits on both ack edges
  task automatic send_word(input logic [5:0] w);
    bit seen;
    pico_data_in = w;
    pico_req_in  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (pico_ack_out) seen = 1'b1;
    end
    check("ack_rise", int'(seen), 1);
    pico_req_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (!pico_ack_out) seen = 1'b1;
    end
    check("ack_fall", int'(seen), 1);
  endtask

  // Count pump high cycles over one full PWM period
  task automatic measure();
    for (int i = 0; i < NC; i++) begin
      a_cnt[i] = 0;
      b_cnt[i] = 0;
    end
    repeat (256) begin
      tick(1);
      for (int i = 0; i < NC; i++) begin
        a_cnt[i] += int'(pump_a_pwm_out[i]);
        b_cnt[i] += int'(pump_b_pwm_out[i]);
      end
    end
  endtask

  task automatic check_pumps(input string tag, input logic [NC-1:0] ea, input logic [NC-1:0] eb);
    measure();
    for (int i = 0; i < NC; i++) begin
      check($sformatf("%s_a%0d", tag, i), a_cnt[i], ea[i] ? DA : 0);
      check($sformatf("%s_b%0d", tag, i), b_cnt[i], eb[i] ? DB : 0);
    end
  endtask

  // Where a channel ends up once sensors have been stable longer than any timeout
  function automatic int m_settle(input int s, input bit f, input bit e);
    if (f && e) return M_FAULT;
    if (s == M_FILL) return f ? M_CIRC : M_FAULT;
    if (s == M_DRAIN) return e ? M_IDLE : M_FAULT;
    return s;
  endfunction

  // Immediate effect of a valid word on a channel
  function automatic int m_word(input int s, input bit anom, input bit f, input bit e);
    if (s == M_IDLE)  return anom ? M_FILL : M_IDLE;
    if (s == M_FILL)  return anom ? M_FILL : M_DRAIN;
    if (s == M_CIRC)  return anom ? M_CIRC : M_DRAIN;
    if (s == M_DRAIN) return anom ? M_FILL : M_DRAIN;
    return (!anom && e && !f) ? M_IDLE : M_FAULT;
  endfunction

  initial begin
    int cnt;
    bit seen;
    int r, ch;
    logic [3:0] an;
    logic [1:0] ch2;
    logic [NC-1:0] fset, eset;
    bit valid;

    vecs[0] = '{6'h0F, 1'b1};
    vecs[1] = '{6'h30, 1'b1};
    vecs[2] = '{6'h20, 1'b0};
    vecs[3] = '{6'h35, 1'b1};
    vecs[4] = '{6'h10, 1'b0};
    vecs[5] = '{6'h1F, 1'b1};

    rst_n = 1'b0;
    pico_data_in = 6'h00;
    pico_req_in = 1'b0;
    float_full_in = 3'b000;
    float_empty_in = 3'b000;
    tick(3);
    check("reset_outputs", int'({pico_ack_out, comm_error_led_out, pump_a_pwm_out, pump_b_pwm_out, fault_out}), 0);
    rst_n = 1'b1;
    tick(2);

    // Ack latency: rises on the third rising edge after req
    pico_data_in = 6'h0F;
    pico_req_in = 1'b1;
    tick(2);
    check("ack_early", int'(pico_ack_out), 0);
    tick(1);
    check("ack_third_edge", int'(pico_ack_out), 1);
    pico_req_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (!pico_ack_out) seen = 1'b1;
    end
    check("ack_fall_first", int'(seen), 1);
    check("invalid_err", int'(comm_error_led_out), 1);
    check("invalid_pumps", int'({pump_a_pwm_out, pump_b_pwm_out}), 0);

    // Word validity table on idle channels
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].word);
      tick(2);
      check($sformatf("vec%0d_err", v), int'(comm_error_led_out), int'(vecs[v].exp_err));
      check($sformatf("vec%0d_fault", v), int'(fault_out), 0);
      check($sformatf("vec%0d_pumps", v), int'({pump_a_pwm_out, pump_b_pwm_out}), 0);
    end

    // Fill then circulate on channel 0
    send_word(6'h04);
    check("fill_err_clear", int'(comm_error_led_out), 0);
    tick(20);
    float_full_in[0] = 1'b1;
    tick(10);
    check("fill_no_fault", int'(fault_out), 0);
    check_pumps("circ", 3'b001, 3'b001);

    // OK word while circulating: drain, then empty returns to idle
    float_full_in[0] = 1'b0;
    tick(5);
    send_word(6'h00);
    tick(5);
    check_pumps("drain", 3'b000, 3'b001);
    float_empty_in[0] = 1'b1;
    tick(10);
    check_pumps("drained", 3'b000, 3'b000);
    check("drained_fault", int'(fault_out), 0);
    float_empty_in[0] = 1'b0;
    tick(5);

    // Fill timeout on channel 1
    pico_data_in = 6'h11;
    pico_req_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (pico_ack_out) seen = 1'b1;
    end
    check("to_ack", int'(seen), 1);
    pico_req_in = 1'b0;
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick(1);
      cnt++;
      if (fault_out[1]) seen = 1'b1;
    end
    check_rng("fill_timeout_cycles", cnt, 49, 53);
    check_pumps("fault", 3'b000, 3'b000);
    check("fault_mask", int'(fault_out), 2);
    send_word(6'h10);
    tick(5);
    check("fault_hold_not_empty", int'(fault_out[1]), 1);
    float_empty_in[1] = 1'b1;
    tick(5);
    send_word(6'h10);
    tick(3);
    check("fault_cleared", int'(fault_out[1]), 0);
    float_empty_in[1] = 1'b0;
    tick(5);

    // Req held high past the ack timeout
    pico_data_in = 6'h20;
    pico_req_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (pico_ack_out) seen = 1'b1;
    end
    check("hold_ack_rise", int'(seen), 1);
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick(1);
      cnt++;
      if (!pico_ack_out) seen = 1'b1;
    end
    check_rng("ack_timeout_cycles", cnt, 58, 62);
    check("ack_timeout_err", int'(comm_error_led_out), 1);
    seen = 1'b0;
    repeat (100) begin
      tick(1);
      if (pico_ack_out) seen = 1'b1;
    end
    check("no_recapture", int'(seen), 0);
    pico_req_in = 1'b0;
    tick(5);
    check("ack_low_after_release", int'(pico_ack_out), 0);
    send_word(6'h20);
    tick(2);
    check("err_clear_after_timeout", int'(comm_error_led_out), 0);

    // Contradictory floats while draining
    send_word(6'h01);
    tick(3);
    float_full_in[0] = 1'b1;
    tick(10);
    float_full_in[0] = 1'b0;
    tick(5);
    send_word(6'h00);
    tick(5);
    check("drain_no_fault", int'(fault_out[0]), 0);
    float_full_in[0] = 1'b1;
    float_empty_in[0] = 1'b1;
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1);
      cnt++;
      if (fault_out[0]) seen = 1'b1;
    end
    check("conflict_fault_cycles", cnt, 3);
    float_full_in[0] = 1'b0;
    tick(5);
    send_word(6'h00);
    tick(3);
    check("conflict_recovered", int'(fault_out[0]), 0);
    float_empty_in[0] = 1'b0;
    tick(5);

    // Asynchronous reset in the middle of filling
    send_word(6'h21);
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", int'({pico_ack_out, comm_error_led_out, pump_a_pwm_out, pump_b_pwm_out, fault_out}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Randomized phase against the settled-state model
    for (int i = 0; i < NC; i++) m_state[i] = M_IDLE;
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < NC; c++) begin
        r = $urandom_range(0, 9);
        fset[c] = (r == 4 || r == 5 || r == 9);
        eset[c] = (r >= 6);
      end
      float_full_in = fset;
      float_empty_in = eset;
      for (int c = 0; c < NC; c++) m_state[c] = m_settle(m_state[c], fset[c], eset[c]);
      tick(450);
      ch = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 4) an = 4'h0;
      else if (r < 9) an = 4'($urandom_range(1, 14));
      else an = 4'hF;
      ch2 = ch[1:0];
      send_word({ch2, an});
      valid = (an != 4'hF) && (ch < NC);
      if (valid)
        m_state[ch] = m_settle(m_word(m_state[ch], an != 4'h0, fset[ch], eset[ch]), fset[ch], eset[ch]);
      tick(450);
      check($sformatf("rnd%0d_err", it), int'(comm_error_led_out), int'(!valid));
      measure();
      for (int c = 0; c < NC; c++) begin
        check($sformatf("rnd%0d_a%0d", it, c), a_cnt[c], (m_state[c] == M_FILL || m_state[c] == M_CIRC) ? DA : 0);
        check($sformatf("rnd%0d_b%0d", it, c), b_cnt[c], (m_state[c] == M_CIRC || m_state[c] == M_DRAIN) ? DB : 0);
        check($sformatf("rnd%0d_fault%0d", it, c), int'(fault_out[c]), int'(m_state[c] == M_FAULT));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
